// File: rtl/main_mem_pkg.sv
// Line/word geometry and FSM encoding shared by the main memory model and the cache controller.
package main_mem_pkg;

  localparam int WORD_BITS   = 32;
  localparam int LINE_WORDS  = 16;
  localparam int LINE_BITS   = LINE_WORDS * WORD_BITS;
  localparam int OFFSET_BITS = 6;
  localparam int BEAT_BITS   = $clog2(LINE_WORDS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    BURST = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } mm_state_t;

endpackage

// File: rtl/mem_word_array.sv
// Word-wide backing store: one synchronous write port, one combinational read port.
module mem_word_array
  import main_mem_pkg::*;
#(
  parameter int MEM_WORDS = 4096
) (
  input  logic                         clk,
  input  logic                         i_we,
  input  logic [$clog2(MEM_WORDS)-1:0] i_waddr,
  input  logic [WORD_BITS-1:0]         i_wdata,
  input  logic [$clog2(MEM_WORDS)-1:0] i_raddr,
  output logic [WORD_BITS-1:0]         o_rdata
);

  // Contents survive reset; the initialiser only gives simulation a known all-zero start.
  logic [WORD_BITS-1:0] r_mem [MEM_WORDS] = '{default: '0};

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/main_mem_ctrl.sv
// Main memory behind the cache: single-word writes and 16-word line fills after a fixed wait.
// One request in flight; requests sampled only in IDLE, read wins over a simultaneous write.
module main_mem_ctrl
  import main_mem_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int READ_LAT  = 4,
  parameter int WRITE_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          main_mem_addr,
  input  logic [WORD_BITS-1:0] main_mem_data_out,
  input  logic                 main_mem_read_req,
  input  logic                 main_mem_write_req,
  output logic [LINE_BITS-1:0] main_mem_data_in,
  output logic                 main_mem_ready,
  output logic                 main_mem_busy
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = 16;

  mm_state_t                            r_state;
  mm_state_t                            w_state_nxt;
  logic [CW-1:0]                        r_lat_cnt;
  logic [BEAT_BITS-1:0]                 r_beat;
  logic [AW-1:0]                        r_widx;
  logic [WORD_BITS-1:0]                 r_wdata;
  logic                                 r_is_rd;
  logic [LINE_WORDS-1:0][WORD_BITS-1:0] r_line;
  logic                                 w_accept;
  logic                                 w_lat_last;
  logic                                 w_mem_we;
  logic [AW-1:0]                        w_rd_addr;
  logic [WORD_BITS-1:0]                 w_rd_data;
  logic                                 w_unused_addr;

  // Byte lane bits and address bits above the store depth alias away.
  assign w_unused_addr = ^{main_mem_addr[31:AW+2], main_mem_addr[1:0]};

  assign w_accept   = (r_state == IDLE) && (main_mem_read_req || main_mem_write_req);
  assign w_lat_last = r_is_rd ? (r_lat_cnt == CW'(READ_LAT - 1))
                              : (r_lat_cnt == CW'(WRITE_LAT - 1));
  assign w_rd_addr  = {r_widx[AW-1:BEAT_BITS], r_beat};

  always_comb begin
    w_state_nxt = r_state;
    w_mem_we    = 1'b0;
    case (r_state)
      IDLE: begin
        if (main_mem_read_req) begin
          w_state_nxt = (READ_LAT == 0) ? BURST : WAIT;
        end else if (main_mem_write_req) begin
          w_state_nxt = (WRITE_LAT == 0) ? WRITE : WAIT;
        end
      end
      WAIT: begin
        if (w_lat_last) begin
          w_state_nxt = r_is_rd ? BURST : WRITE;
        end
      end
      BURST: begin
        if (r_beat == BEAT_BITS'(LINE_WORDS - 1)) begin
          w_state_nxt = DONE;
        end
      end
      WRITE: begin
        w_mem_we    = 1'b1;
        w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_lat_cnt <= '0;
      r_beat    <= '0;
      r_widx    <= '0;
      r_wdata   <= '0;
      r_is_rd   <= 1'b0;
      r_line    <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_widx    <= main_mem_addr[AW+1:2];
            r_wdata   <= main_mem_data_out;
            r_is_rd   <= main_mem_read_req;
            r_lat_cnt <= '0;
            r_beat    <= '0;
          end
        end
        WAIT: r_lat_cnt <= r_lat_cnt + 1'b1;
        BURST: begin
          r_line[r_beat] <= w_rd_data;
          r_beat         <= r_beat + 1'b1;
        end
        default: ;
      endcase
    end
  end

  mem_word_array #(
    .MEM_WORDS (MEM_WORDS)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (r_widx),
    .i_wdata (r_wdata),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  assign main_mem_data_in = r_line;
  assign main_mem_ready   = (r_state == DONE);
  assign main_mem_busy    = (r_state != IDLE);

endmodule
